// File: rtl/axis_fifo_wr_arb.sv
// axis_fifo_wr_arb: round-robin arbiter that lets NUM_REQ AXI-Stream requesters
// take turns writing whole packets into one downstream FIFO.
// Ports:
//   clk_i            single clock, all state on its rising edge
//   s_rst_i          synchronous active-high reset
//   s_axis_tdata_i   requester data, requester k at [k*DATA_WIDTH +: DATA_WIDTH]
//   s_axis_tvalid_i  per-requester valid
//   s_axis_tlast_i   per-requester end of packet
//   s_axis_tready_o  per-requester ready (only the granted lane, only when FIFO not full)
//   fifo_wr_en_o     FIFO write strobe
//   fifo_data_o      FIFO word {[src id], tlast, tdata}
//   fifo_full_i      FIFO full
//   grant_o          one-hot grant, zero when idle
//   busy_o           high while a packet is in transfer
// Build macro ARB_SRC_ID_EN: when defined, the granted requester index is
// prepended to every FIFO word.
module axis_fifo_wr_arb #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ = 4,
    localparam int ID_W = $clog2(NUM_REQ),
`ifdef ARB_SRC_ID_EN
    localparam int FIFO_W = DATA_WIDTH + 1 + ID_W
`else
    localparam int FIFO_W = DATA_WIDTH + 1
`endif
) (
    input  logic                          clk_i,
    input  logic                          s_rst_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] s_axis_tdata_i,
    input  logic [NUM_REQ-1:0]            s_axis_tvalid_i,
    input  logic [NUM_REQ-1:0]            s_axis_tlast_i,
    output logic [NUM_REQ-1:0]            s_axis_tready_o,
    output logic                          fifo_wr_en_o,
    output logic [FIFO_W-1:0]             fifo_data_o,
    input  logic                          fifo_full_i,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic                          busy_o
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] XFER = 1'b1;

    logic [0:0]            state;
    logic [ID_W-1:0]       last_ptr;
    logic [ID_W-1:0]       gidx;
    logic [ID_W-1:0]       nxt;
    logic [NUM_REQ-1:0]    grant;
    logic                  found;
    logic                  sel_valid;
    logic                  sel_last;
    logic                  wr;
    logic [DATA_WIDTH-1:0] sel_data;

    // First valid requester scanning upward from last_ptr+1, wrapping.
    always_comb begin
        nxt = last_ptr;
        found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!found && s_axis_tvalid_i[(int'(last_ptr) + i) % NUM_REQ]) begin
                found = 1'b1;
                nxt = ID_W'((int'(last_ptr) + i) % NUM_REQ);
            end
        end
    end

    // The grant register is one-hot in XFER and zero in IDLE, so it doubles
    // as the lane select for the data/valid/last mux.
    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        sel_valid = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sel_data = sel_data | (s_axis_tdata_i[k*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant[k]}});
            sel_last = sel_last | (s_axis_tlast_i[k] & grant[k]);
            sel_valid = sel_valid | (s_axis_tvalid_i[k] & grant[k]);
        end
    end

    // Outputs are also gated by reset so nothing leaks out in the cycle reset
    // is first seen, before the registers have cleared.
    assign wr              = sel_valid & ~fifo_full_i & ~s_rst_i;
    assign fifo_wr_en_o    = wr;
    assign s_axis_tready_o = grant & {NUM_REQ{~fifo_full_i & ~s_rst_i}};
    assign grant_o         = grant & {NUM_REQ{~s_rst_i}};
    assign busy_o          = (state == XFER) & ~s_rst_i;

`ifdef ARB_SRC_ID_EN
    assign fifo_data_o = {gidx, sel_last, sel_data};
`else
    assign fifo_data_o = {sel_last, sel_data};
`endif

    always_ff @(posedge clk_i) begin
        if (s_rst_i) begin
            state    <= IDLE;
            last_ptr <= ID_W'(NUM_REQ - 1);
            gidx     <= '0;
            grant    <= '0;
        end else if (state == IDLE) begin
            if (found) begin
                state <= XFER;
                gidx  <= nxt;
                grant <= NUM_REQ'(1) << nxt;
            end
        end else if (wr && sel_last) begin
            state    <= IDLE;
            last_ptr <= gidx;
            grant    <= '0;
        end
    end
endmodule

// File: doc/axis_fifo_wr_arb.md
AXIS_FIFO_WR_ARB -- requirements
Module: axis_fifo_wr_arb

Interface
- REQ-001 Parameter DATA_WIDTH, default 32, is the per-requester AXI-Stream tdata width in bits (>=1).
- REQ-002 Parameter NUM_REQ, default 4, is the number of requesters (2..8).
- REQ-003 Derived width ID_W = $clog2(NUM_REQ).
- REQ-004 Derived width FIFO_W = DATA_WIDTH+1+ID_W with ARB_SRC_ID_EN defined, else DATA_WIDTH+1.
- REQ-005 clk_i  in  1  single clock; all logic on its rising edge.
- REQ-006 s_rst_i  in  1  reset, synchronous, active-high.
- REQ-007 s_axis_tdata_i  in  NUM_REQ*DATA_WIDTH  requester data, requester k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- REQ-008 s_axis_tvalid_i  in  NUM_REQ  per-requester valid.
- REQ-009 s_axis_tlast_i  in  NUM_REQ  per-requester end of packet.
- REQ-010 s_axis_tready_o  out  NUM_REQ  per-requester ready.
- REQ-011 fifo_wr_en_o  out  1  write strobe to the downstream FIFO.
- REQ-012 fifo_data_o  out  FIFO_W  FIFO write word {[src id], tlast, tdata}, tdata in the LSBs.
- REQ-013 fifo_full_i  in  1  downstream FIFO full.
- REQ-014 grant_o  out  NUM_REQ  one-hot current grant, all zero when idle.
- REQ-015 busy_o  out  1  high while a packet is in transfer.

Function
- REQ-016 FSM states: IDLE, XFER.
- REQ-017 IDLE: with any tvalid high, register grant to the first valid requester scanning upward (wrapping) from last_ptr+1, then enter XFER next cycle.
- REQ-018 IDLE: with no tvalid high, stay in IDLE with grant_o = 0.
- REQ-019 Grant latency: exactly one cycle from tvalid seen in IDLE to grant_o/busy_o high.
- REQ-020 XFER: tready_o[g] = ~fifo_full_i for granted requester g; all other tready bits = 0.
- REQ-021 Non-granted tready bits and all tready bits in IDLE shall be 0.
- REQ-022 XFER: fifo_wr_en_o = tvalid[g] & ~fifo_full_i, combinational, zero added latency.
- REQ-023 fifo_data_o shall carry the granted lane's tdata and tlast in the same cycle.
- REQ-024 Grant holds for a whole packet; it is released only on an accepted beat with tlast=1.
- REQ-025 On that beat: last_ptr <= g, FSM -> IDLE.
- REQ-026 A new arbitration follows, so there is one idle bubble cycle between packets.
- REQ-027 fifo_full_i high: no write and no tready; the beat is held by the requester; FSM and grant are unchanged.
- REQ-028 tvalid dropping mid-packet: grant is held and no write occurs.
- REQ-029 Single-beat packet (tlast on first beat): one write, then return to IDLE.
- REQ-030 Round-robin pointer wraps NUM_REQ-1 -> 0; no requester starves while others hold continuous traffic.
- REQ-031 fifo_wr_en_o shall never assert while fifo_full_i is high.

Reset
- REQ-032 While s_rst_i=1: FSM=IDLE, last_ptr=NUM_REQ-1 (first grant scan starts at requester 0), grant_o=0, busy_o=0, s_axis_tready_o=0, fifo_wr_en_o=0.
- REQ-033 fifo_data_o is don't-care during reset.
- REQ-034 Reset mid-packet abandons the packet; the partial packet already written stays in the FIFO, and the arbiter takes no cleanup action.
- REQ-035 Arbitration may begin in the first cycle after s_rst_i deasserts.

Configuration
- REQ-036 Macro ARB_SRC_ID_EN defined: fifo_data_o[FIFO_W-1 -: ID_W] = binary index of granted requester.
- REQ-037 Macro ARB_SRC_ID_EN undefined: no ID field; FIFO_W = DATA_WIDTH+1; all other behaviour identical.

Verification
- REQ-038 Reset, then tvalid=4'b0101 simultaneously with 3-beat packets -> grant req0 first (grant_o=4'b0001 one cycle after tvalid), 3 writes, 1 idle cycle, then grant req2 (4'b0100).
- REQ-039 All four requesters continuously valid with 1-beat packets -> grant order 0,1,2,3,0 with a write every second cycle.
- REQ-040 fifo_full_i high for 5 cycles mid-packet from req1 -> fifo_wr_en_o=0 and tready_o=0 for those 5 cycles, grant stays 4'b0010, then data resumes in order with no loss or duplication.
- REQ-041 ARB_SRC_ID_EN defined, NUM_REQ=4, req3 sends tdata 32'hDEADBEEF with tlast=1 -> fifo_data_o = {2'b11, 1'b1, 32'hDEADBEEF}, FIFO_W=35.
- REQ-042 s_rst_i pulsed during beat 2 of a 4-beat packet from req1 -> next cycle grant_o=0, busy_o=0; next arbitration starts scan at req0.
- REQ-043 Bench scoreboard: per-requester packet contents read back from the FIFO match sent packets, with packets never interleaved.
